// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Opcodes, flag bit positions and FSM encodings for alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] ALU_SEQ_MULU = 3'd0;
    localparam logic [2:0] ALU_SEQ_MULS = 3'd1;
    localparam logic [2:0] ALU_SEQ_DIVU = 3'd2;
    localparam logic [2:0] ALU_SEQ_SHL  = 3'd3;
    localparam logic [2:0] ALU_SEQ_SHR  = 3'd4;
    localparam logic [2:0] ALU_SEQ_ASR  = 3'd5;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_RUN  = C_ST_RUN,
        ST_DONE = C_ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_step
// Purpose  : One iteration of the sequential ALU datapath (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_step
    import alu_seq_pkg::*;
#(
    parameter int DataWidth = 16
) (
    input  logic [2:0]           i_op,
    input  logic [DataWidth-1:0] i_acc,
    input  logic [DataWidth-1:0] i_lo,
    input  logic [DataWidth-1:0] i_mcand,
    input  logic                 i_carry,
    output logic [DataWidth-1:0] o_acc,
    output logic [DataWidth-1:0] o_lo,
    output logic                 o_carry
);

    logic [DataWidth-1:0] w_addend;
    logic [DataWidth:0]   w_sum;
    logic [DataWidth:0]   w_rem_sh;
    logic [DataWidth:0]   w_diff;

    assign w_addend = i_lo[0] ? i_mcand : '0;
    assign w_sum    = {1'b0, i_acc} + {1'b0, w_addend};
    // Partial remainder is always below the divisor, so the shifted value fits DataWidth+1 bits.
    assign w_rem_sh = {i_acc, i_lo[DataWidth-1]};
    assign w_diff   = w_rem_sh - {1'b0, i_mcand};

    always_comb begin
        o_acc   = i_acc;
        o_lo    = i_lo;
        o_carry = i_carry;
        case (i_op)
            ALU_SEQ_MULU, ALU_SEQ_MULS: begin
                o_acc = w_sum[DataWidth:1];
                o_lo  = {w_sum[0], i_lo[DataWidth-1:1]};
            end
            ALU_SEQ_DIVU: begin
                if (!w_diff[DataWidth]) begin
                    o_acc = w_diff[DataWidth-1:0];
                    o_lo  = {i_lo[DataWidth-2:0], 1'b1};
                end else begin
                    o_acc = w_rem_sh[DataWidth-1:0];
                    o_lo  = {i_lo[DataWidth-2:0], 1'b0};
                end
            end
            ALU_SEQ_SHL: begin
                o_lo    = {i_lo[DataWidth-2:0], 1'b0};
                o_carry = i_lo[DataWidth-1];
            end
            ALU_SEQ_SHR: begin
                o_lo    = {1'b0, i_lo[DataWidth-1:1]};
                o_carry = i_lo[0];
            end
            ALU_SEQ_ASR: begin
                o_lo    = {i_lo[DataWidth-1], i_lo[DataWidth-1:1]};
                o_carry = i_lo[0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Multi-cycle multiply / divide / shift unit, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int CountWidth = $clog2(DataWidth) + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic [2:0]           func_op_i,
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    input  logic [3:0]           flags_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [DataWidth-1:0] y_o,
    output logic [DataWidth-1:0] y_hi_o,
    output logic [3:0]           flags_o
);

    localparam logic [DataWidth-1:0]  c_dw_d = DataWidth'(DataWidth);
    localparam logic [CountWidth-1:0] c_dw_n = CountWidth'(DataWidth);

    state_t                r_state, w_state_nxt;
    logic [CountWidth-1:0] r_cnt;
    logic [2:0]            r_op;
    logic [DataWidth-1:0]  r_acc, r_lo, r_mcand;
    logic                  r_carry, r_neg;
    logic [3:0]            r_flags_in;
    logic [DataWidth-1:0]  r_y, r_y_hi;
    logic [3:0]            r_flags;

    logic                  w_accept, w_run_last, w_load_out;
    logic [DataWidth-1:0]  w_init_acc, w_init_lo, w_init_mcand;
    logic                  w_init_neg, w_init_divz;
    logic [CountWidth-1:0] w_init_n;
    logic [DataWidth-1:0]  w_step_acc, w_step_lo;
    logic                  w_step_c;
    logic [2:0]            w_src_op;
    logic [DataWidth-1:0]  w_src_acc, w_src_lo;
    logic                  w_src_c, w_src_neg, w_src_divz;
    logic [3:0]            w_src_flags;
    logic [2*DataWidth-1:0] w_full, w_prod;
    logic [DataWidth-1:0]  w_res_y, w_res_hi;
    logic [3:0]            w_res_flags;

    assign ready_o    = (r_state != ST_RUN);
    assign busy_o     = (r_state == ST_RUN);
    assign valid_o    = (r_state == ST_DONE);
    assign y_o        = r_y;
    assign y_hi_o     = r_y_hi;
    assign flags_o    = r_flags;

    assign w_accept   = start_i && ready_o;
    assign w_run_last = (r_state == ST_RUN) && (r_cnt == CountWidth'(1));
    assign w_load_out = (w_accept && (w_init_n == '0)) || w_run_last;

    // Operand setup at accept; MULS runs on magnitudes and fixes the sign at the end.
    always_comb begin
        w_init_acc   = '0;
        w_init_lo    = a_i;
        w_init_mcand = b_i;
        w_init_neg   = 1'b0;
        w_init_divz  = 1'b0;
        w_init_n     = '0;
        case (func_op_i)
            ALU_SEQ_MULU: begin
                w_init_lo    = b_i;
                w_init_mcand = a_i;
                w_init_n     = c_dw_n;
            end
            ALU_SEQ_MULS: begin
                w_init_lo    = b_i[DataWidth-1] ? -b_i : b_i;
                w_init_mcand = a_i[DataWidth-1] ? -a_i : a_i;
                w_init_neg   = a_i[DataWidth-1] ^ b_i[DataWidth-1];
                w_init_n     = c_dw_n;
            end
            ALU_SEQ_DIVU: begin
                if (b_i == '0) begin
                    w_init_divz = 1'b1;
                    w_init_acc  = a_i;
                    w_init_lo   = '1;
                end else begin
                    w_init_n    = c_dw_n;
                end
            end
            ALU_SEQ_SHL, ALU_SEQ_SHR, ALU_SEQ_ASR: begin
                w_init_n = (b_i >= c_dw_d) ? c_dw_n : CountWidth'(b_i);
            end
            default: ;
        endcase
    end

    alu_seq_step #(
        .DataWidth (DataWidth)
    ) u_step (
        .i_op    (r_op),
        .i_acc   (r_acc),
        .i_lo    (r_lo),
        .i_mcand (r_mcand),
        .i_carry (r_carry),
        .o_acc   (w_step_acc),
        .o_lo    (w_step_lo),
        .o_carry (w_step_c)
    );

    // Results come from the accept-time setup (zero-step ops) or from the final iteration.
    assign w_src_op    = w_accept ? func_op_i         : r_op;
    assign w_src_acc   = w_accept ? w_init_acc        : w_step_acc;
    assign w_src_lo    = w_accept ? w_init_lo         : w_step_lo;
    assign w_src_c     = w_accept ? flags_i[FLAG_C]   : w_step_c;
    assign w_src_neg   = w_accept ? w_init_neg        : r_neg;
    assign w_src_divz  = w_accept ? w_init_divz       : 1'b0;
    assign w_src_flags = w_accept ? flags_i           : r_flags_in;

    assign w_full = {w_src_acc, w_src_lo};
    assign w_prod = ((w_src_op == ALU_SEQ_MULS) && w_src_neg) ? -w_full : w_full;

    always_comb begin
        w_res_y     = w_src_lo;
        w_res_hi    = '0;
        w_res_flags = w_src_flags;
        case (w_src_op)
            ALU_SEQ_MULU, ALU_SEQ_MULS: begin
                w_res_y             = w_prod[DataWidth-1:0];
                w_res_hi            = w_prod[2*DataWidth-1:DataWidth];
                w_res_flags[FLAG_Z] = (w_prod == '0);
                w_res_flags[FLAG_N] = w_res_hi[DataWidth-1];
                w_res_flags[FLAG_C] = (w_src_op == ALU_SEQ_MULU) ? (w_res_hi != '0)
                                    : (w_res_hi != {DataWidth{w_res_y[DataWidth-1]}});
            end
            ALU_SEQ_DIVU: begin
                w_res_hi            = w_src_acc;
                w_res_flags[FLAG_Z] = (w_res_y == '0);
                w_res_flags[FLAG_N] = w_res_y[DataWidth-1];
                w_res_flags[FLAG_C] = 1'b0;
                w_res_flags[FLAG_V] = w_src_divz;
            end
            ALU_SEQ_SHL, ALU_SEQ_SHR, ALU_SEQ_ASR: begin
                w_res_flags[FLAG_Z] = (w_res_y == '0);
                w_res_flags[FLAG_N] = w_res_y[DataWidth-1];
                w_res_flags[FLAG_C] = w_src_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = (w_init_n == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_run_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept) w_state_nxt = (w_init_n == '0) ? ST_DONE : ST_RUN;
                else          w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_acc      <= '0;
            r_lo       <= '0;
            r_mcand    <= '0;
            r_carry    <= 1'b0;
            r_neg      <= 1'b0;
            r_flags_in <= '0;
            r_y        <= '0;
            r_y_hi     <= '0;
            r_flags    <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= w_init_n;
                r_op       <= func_op_i;
                r_acc      <= w_init_acc;
                r_lo       <= w_init_lo;
                r_mcand    <= w_init_mcand;
                r_carry    <= flags_i[FLAG_C];
                r_neg      <= w_init_neg;
                r_flags_in <= flags_i;
            end else if (r_state == ST_RUN) begin
                r_cnt   <= r_cnt - CountWidth'(1);
                r_acc   <= w_step_acc;
                r_lo    <= w_step_lo;
                r_carry <= w_step_c;
            end
            if (w_load_out) begin
                r_y     <= w_res_y;
                r_y_hi  <= w_res_hi;
                r_flags <= w_res_flags;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Scoreboard testbench for alu_seq (DataWidth = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] hi;
        logic [3:0]  fl;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        start_i;
    logic [2:0]  func_op_i;
    logic [15:0] a_i, b_i;
    logic [3:0]  flags_i;
    logic        ready_o, busy_o, valid_o;
    logic [15:0] y_o, y_hi_o;
    logic [3:0]  flags_o;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    alu_seq #(.DataWidth(16)) dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .start_i   (start_i),
        .func_op_i (func_op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .flags_i   (flags_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .y_o       (y_o),
        .y_hi_o    (y_hi_o),
        .flags_o   (flags_o)
    );

    always #5 clk = ~clk;

    // Behavioural reference; lat counts edges with the accepting edge as edge 1.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] fi);
        exp_t e;
        logic [31:0] p;
        logic signed [31:0] sa, sbv;
        int n;
        e.y = a; e.hi = '0; e.fl = fi; n = 0;
        sa  = {{16{a[15]}}, a};
        sbv = {{16{b[15]}}, b};
        case (op)
            ALU_SEQ_MULU, ALU_SEQ_MULS: begin
                if (op == ALU_SEQ_MULU) p = {16'h0, a} * {16'h0, b};
                else                    p = sa * sbv;
                e.y = p[15:0]; e.hi = p[31:16]; n = 16;
                e.fl[0] = (p == 32'h0);
                e.fl[2] = p[31];
                e.fl[1] = (op == ALU_SEQ_MULU) ? (p[31:16] != 16'h0) : (p[31:16] != {16{p[15]}});
            end
            ALU_SEQ_DIVU: begin
                if (b == 16'h0) begin
                    e.y = 16'hFFFF; e.hi = a; e.fl = 4'b1100;
                end else begin
                    e.y = a / b; e.hi = a % b; n = 16;
                    e.fl = {1'b0, e.y[15], 1'b0, (e.y == 16'h0)};
                end
            end
            ALU_SEQ_SHL, ALU_SEQ_SHR, ALU_SEQ_ASR: begin
                n = (b >= 16'd16) ? 16 : int'(b);
                if (op == ALU_SEQ_SHL) begin
                    e.y = a << n;
                    if (n > 0) e.fl[1] = a[16-n];
                end else if (op == ALU_SEQ_SHR) begin
                    e.y = a >> n;
                    if (n > 0) e.fl[1] = a[n-1];
                end else begin
                    e.y = 16'(sa >>> n);
                    if (n > 0) e.fl[1] = a[n-1];
                end
                e.fl[0] = (e.y == 16'h0);
                e.fl[2] = e.y[15];
            end
            default: ;
        endcase
        e.lat = n + 1;
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] fi);
        func_op_i = op; a_i = a; b_i = b; flags_i = fi; start_i = 1'b1;
        sb.push_back(model(op, a, b, fi));
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_valid(output int edges, output int busy_cyc);
        edges = 1; busy_cyc = 0;
        while (!valid_o && edges < 64) begin
            if (busy_o) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; start_i = 1'b0; func_op_i = '0; a_i = '0; b_i = '0; flags_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_ctrl: got rdy/busy/vld=%b want 100", {ready_o, busy_o, valid_o});
        end
        n_checks++;
        if ({y_o, y_hi_o, flags_o} !== 36'h0) begin
            n_errors++;
            $display("FAIL reset_data: got y=%h hi=%h fl=%b want zeros", y_o, y_hi_o, flags_o);
        end
        reset_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_table(input string name, input int cnt, input logic [2:0] op[8],
                              input logic [15:0] av[8], input logic [15:0] bv[8], input logic [3:0] fv[8]);
        int edges, busy_cyc;
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            issue(op[i], av[i], bv[i], fv[i]);
            wait_valid(edges, busy_cyc);
            e = sb.pop_front();
            n_checks++;
            if (valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL %s[%0d]_timeout: no valid_o after %0d edges, want %0d", name, i, edges, e.lat);
            end else begin
                n_checks++;
                if ({y_o, y_hi_o, flags_o} !== {e.y, e.hi, e.fl}) begin
                    n_errors++;
                    $display("FAIL %s[%0d]_result: got y=%h hi=%h fl=%b want y=%h hi=%h fl=%b",
                             name, i, y_o, y_hi_o, flags_o, e.y, e.hi, e.fl);
                end
                n_checks++;
                if (edges !== e.lat || busy_cyc !== e.lat - 1) begin
                    n_errors++;
                    $display("FAIL %s[%0d]_latency: got edge=%0d busy=%0d want edge=%0d busy=%0d",
                             name, i, edges, busy_cyc, e.lat, e.lat - 1);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        test_table("mul", 5,
            '{ALU_SEQ_MULU, ALU_SEQ_MULS, ALU_SEQ_MULS, ALU_SEQ_MULU, ALU_SEQ_MULS, 3'd0, 3'd0, 3'd0},
            '{16'h1234, 16'hFFFE, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0, 16'h0, 16'h0},
            '{16'h0010, 16'h0003, 16'h8000, 16'hFFFF, 16'h8000, 16'h0, 16'h0, 16'h0},
            '{4'b0000, 4'b0000, 4'b1000, 4'b0101, 4'b0000, 4'b0, 4'b0, 4'b0});
    endtask

    task automatic test_divu();
        test_table("div", 4,
            '{ALU_SEQ_DIVU, ALU_SEQ_DIVU, ALU_SEQ_DIVU, ALU_SEQ_DIVU, 3'd0, 3'd0, 3'd0, 3'd0},
            '{16'd100, 16'd5, 16'd0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0},
            '{16'd7, 16'd0, 16'd3, 16'd1, 16'h0, 16'h0, 16'h0, 16'h0},
            '{4'b1010, 4'b0000, 4'b0000, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0});
    endtask

    task automatic test_shift();
        test_table("shift", 7,
            '{ALU_SEQ_SHR, ALU_SEQ_ASR, ALU_SEQ_SHL, ALU_SEQ_SHL, ALU_SEQ_ASR, ALU_SEQ_SHR, 3'd6, 3'd7},
            '{16'h8001, 16'h8000, 16'h1234, 16'h8001, 16'h4321, 16'hF0F0, 16'hBEEF, 16'h0000},
            '{16'd1, 16'd20, 16'd0, 16'd16, 16'd4, 16'd15, 16'd9, 16'd3},
            '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b1011, 4'b0101});
    endtask

    task automatic test_random();
        logic [2:0]  op[8];
        logic [15:0] av[8], bv[8];
        logic [3:0]  fv[8];
        for (int i = 0; i < 8; i++) begin
            op[i] = 3'($urandom_range(0, 7));
            av[i] = 16'($urandom);
            bv[i] = (op[i] >= ALU_SEQ_SHL) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            fv[i] = 4'($urandom);
        end
        test_table("rand", 8, op, av, bv, fv);
    endtask

    task automatic test_handshake();
        int edges, busy_cyc;
        exp_t e;
        issue(ALU_SEQ_MULU, 16'h00FF, 16'h0101, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL hs_busy: got rdy=%b busy=%b want rdy=0 busy=1", ready_o, busy_o);
        end
        func_op_i = ALU_SEQ_DIVU; a_i = 16'h0042; b_i = 16'h0000; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_valid(edges, busy_cyc);
        e = sb.pop_front();
        n_checks++;
        if (valid_o !== 1'b1 || {y_o, y_hi_o, flags_o} !== {e.y, e.hi, e.fl} || edges + 4 !== e.lat) begin
            n_errors++;
            $display("FAIL hs_ignored: got vld=%b y=%h hi=%h fl=%b edge=%0d want y=%h hi=%h fl=%b edge=%0d",
                     valid_o, y_o, y_hi_o, flags_o, edges + 4, e.y, e.hi, e.fl, e.lat);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100) begin
            n_errors++;
            $display("FAIL hs_idle: got rdy/busy/vld=%b want 100", {ready_o, busy_o, valid_o});
        end
    endtask

    task automatic test_back_to_back();
        int edges, busy_cyc;
        exp_t e;
        issue(ALU_SEQ_MULU, 16'h0003, 16'h0007, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            wait_valid(edges, busy_cyc);
            e = sb.pop_front();
            n_checks++;
            if (valid_o !== 1'b1 || {y_o, y_hi_o, flags_o} !== {e.y, e.hi, e.fl} || edges !== e.lat) begin
                n_errors++;
                $display("FAIL b2b[%0d]: got vld=%b y=%h hi=%h fl=%b edge=%0d want y=%h hi=%h fl=%b edge=%0d",
                         k, valid_o, y_o, y_hi_o, flags_o, edges, e.y, e.hi, e.fl, e.lat);
            end
            n_checks++;
            if (ready_o !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b[%0d]_ready_in_done: got %b want 1", k, ready_o);
            end
            if (k == 0) begin
                issue(ALU_SEQ_MULS, 16'hFFF0, 16'h0010, 4'b0010);
                n_checks++;
                if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_reaccept: got rdy=%b busy=%b want rdy=0 busy=1", ready_o, busy_o);
                end
            end else if (k == 1) begin
                issue(ALU_SEQ_SHR, 16'h5A5A, 16'd0, 4'b0010);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int edges, busy_cyc, seen;
        exp_t e;
        issue(ALU_SEQ_DIVU, 16'd1000, 16'd3, 4'b0000);
        void'(sb.pop_back());
        repeat (6) @(posedge clk);
        #3;
        reset_ni = 1'b0;
        #1;
        n_checks++;
        if ({ready_o, busy_o, valid_o} !== 3'b100 || {y_o, y_hi_o, flags_o} !== 36'h0) begin
            n_errors++;
            $display("FAIL async_reset: got rdy/busy/vld=%b y=%h hi=%h fl=%b want 100 and zeros",
                     {ready_o, busy_o, valid_o}, y_o, y_hi_o, flags_o);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen);
        end
        issue(ALU_SEQ_MULU, 16'd3, 16'd5, 4'b0000);
        wait_valid(edges, busy_cyc);
        e = sb.pop_front();
        n_checks++;
        if (valid_o !== 1'b1 || y_o !== 16'd15 || {y_hi_o, flags_o} !== {e.hi, e.fl}) begin
            n_errors++;
            $display("FAIL post_reset_mul: got vld=%b y=%h hi=%h fl=%b want y=000f hi=%h fl=%b",
                     valid_o, y_o, y_hi_o, flags_o, e.hi, e.fl);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_divu();
        test_shift();
        test_random();
        test_handshake();
        test_back_to_back();
        test_async_reset();
        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
